// File: rtl/counter_event_logger.sv
// Timestamping event logger: detects rising edges on the counter compare flags,
// stamps them with a free-running cycle count and queues them for host readout.
module counter_event_logger #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 29
) (
  input  logic                     clk1,
  input  logic                     reset1,
  input  logic [2:0]               ev,
  input  logic                     enable,
  input  logic                     pop,
  input  logic                     clr,
  output logic [TS_W+2:0]          dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drops
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = TS_W + 3;

  logic [TS_W-1:0] ts;
  logic [2:0]      ev_q;
  logic [2:0]      edges;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   cnt;
  logic [EW-1:0]   mem [DEPTH];

  logic push_req;
  logic do_pop;
  logic do_write;
  logic drop;

  // A full FIFO still accepts a push when the same cycle frees a slot.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path so no latch is inferred.
    edges    = ev & ~ev_q;
    empty    = (cnt == '0);
    full     = (cnt == LW'(DEPTH));
    push_req = enable && (edges != 3'b000);
    do_pop   = pop && !empty && !clr;
    do_write = push_req && !clr && (!full || do_pop);
    drop     = push_req && !clr && full && !do_pop;
    level    = cnt;
    dout     = empty ? '0 : mem[rd_ptr];
  end

  // ev_q resets high so flags already asserted at reset release are not logged.
  always_ff @(posedge clk1 or posedge reset1) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset1) begin
      ts   <= '0;
      ev_q <= 3'b111;
    end else begin
      ts   <= ts + TS_W'(1);
      ev_q <= ev;
    end
  end

  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      drops    <= 8'd0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      drops    <= 8'd0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_write, do_pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drops != 8'hFF) drops <= drops + 8'd1;
      end
    end
  end

  // NOTE: storage has no reset; an empty FIFO gates dout to 0, so stale entries are never visible.
  always_ff @(posedge clk1) begin
    if (do_write) mem[wr_ptr] <= {edges, ts};
  end

endmodule

// File: tb/tb_counter_event_logger.sv
// Scoreboard bench for counter_event_logger; a second narrow-timestamp instance
// shares the stimulus to exercise timestamp wrap within a short run.
module tb_counter_event_logger;

  localparam int DEPTH = 16;

  logic        clk1 = 1'b0;
  logic        reset1 = 1'b1;
  logic [2:0]  ev = 3'b000;
  logic        enable = 1'b1;
  logic        pop = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] dout;
  logic        empty, full, overflow;
  logic [4:0]  level;
  logic [7:0]  drops;

  logic [7:0]  dout2;
  logic        empty2, full2, overflow2;
  logic [2:0]  level2;
  logic [7:0]  drops2;

  int checks = 0;
  int failures = 0;

  logic [31:0] q[$];
  logic        m_ovf;
  int          m_drops;
  logic [28:0] m_ts;
  logic [2:0]  m_evq;

  counter_event_logger #(.DEPTH(DEPTH), .TS_W(29)) dut (
    .clk1(clk1), .reset1(reset1), .ev(ev), .enable(enable), .pop(pop), .clr(clr),
    .dout(dout), .empty(empty), .full(full), .level(level),
    .overflow(overflow), .drops(drops)
  );

  counter_event_logger #(.DEPTH(4), .TS_W(5)) dut_narrow (
    .clk1(clk1), .reset1(reset1), .ev(ev), .enable(enable), .pop(pop), .clr(clr),
    .dout(dout2), .empty(empty2), .full(full2), .level(level2),
    .overflow(overflow2), .drops(drops2)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_head;
    exp_head = (q.size() != 0) ? q[0] : 32'd0;
    check({tag, ".dout"},     dout,     exp_head);
    check({tag, ".level"},    32'(level), 32'(q.size()));
    check({tag, ".empty"},    32'(empty), 32'(q.size() == 0));
    check({tag, ".full"},     32'(full),  32'(q.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".drops"},    32'(drops), 32'(m_drops));
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
    m_ts    = '0;
    m_evq   = 3'b111;
  endtask

  // Drive one cycle of inputs, predict the result, then compare after the edge.
  task automatic cycle(input logic [2:0] e, input logic en, input logic p, input logic c);
    logic [2:0] edges;
    bit do_pop, do_push;
    ev = e; enable = en; pop = p; clr = c;
    edges   = e & ~m_evq;
    m_evq   = e;
    do_pop  = p && (q.size() != 0);
    do_push = en && (edges != 3'b000);
    if (c) begin
      q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else if (do_push && q.size() == DEPTH && !do_pop) begin
      m_ovf = 1'b1;
      if (m_drops < 255) m_drops++;
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({edges, m_ts});
    end
    @(posedge clk1);
    m_ts = m_ts + 29'd1;
    #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset(input logic [2:0] e);
    reset1 = 1'b1; ev = e; enable = 1'b1; pop = 1'b0; clr = 1'b0;
    @(posedge clk1);
    #2;
    model_reset();
    check_outputs("rst");
    #1;
    reset1 = 1'b0;
  endtask

  task automatic edge0(input logic en);
    cycle(3'b001, en, 1'b0, 1'b0);
    cycle(3'b000, en, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_last;

    // Flag already high at release is not logged; later rise of bit1 at ts=100.
    do_reset(3'b001);
    while (m_ts != 29'd100) cycle(3'b001, 1'b1, 1'b0, 1'b0);
    cycle(3'b011, 1'b1, 1'b0, 1'b0);
    check("ts100_dout", dout, 32'h4000_0064);
    check("ts100_level", 32'(level), 32'd1);

    // Two flags rising together form one entry.
    do_reset(3'b000);
    while (m_ts != 29'd5) cycle(3'b000, 1'b1, 1'b0, 1'b0);
    cycle(3'b101, 1'b1, 1'b0, 1'b0);
    check("multi_dout", dout, 32'hA000_0005);
    cycle(3'b000, 1'b1, 1'b0, 1'b1);

    // Fill, then push and pop together while full.
    for (int i = 0; i < DEPTH; i++) edge0(1'b1);
    check("fill_level", 32'(level), 32'd16);
    check("fill_full", 32'(full), 32'd1);
    exp_last = {3'b001, m_ts};
    cycle(3'b001, 1'b1, 1'b1, 1'b0);
    check("pp_level", 32'(level), 32'd16);
    check("pp_overflow", 32'(overflow), 32'd0);
    cycle(3'b000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(3'b000, 1'b1, 1'b1, 1'b0);
    check("pp_last", dout, exp_last);
    cycle(3'b000, 1'b1, 1'b1, 1'b0);

    // Pop on empty has no effect.
    cycle(3'b000, 1'b1, 1'b1, 1'b0);
    check("pop_empty_level", 32'(level), 32'd0);
    check("pop_empty_dout", dout, 32'd0);

    // Overflow and drop-count saturation.
    for (int i = 0; i < DEPTH; i++) edge0(1'b1);
    exp_last = dout;
    edge0(1'b1);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drops", 32'(drops), 32'd1);
    check("ovf_head", dout, exp_last);
    for (int i = 0; i < 257; i++) edge0(1'b1);
    check("drops_sat", 32'(drops), 32'd255);

    // Drain to 7, then clear with a simultaneous edge.
    for (int i = 0; i < 9; i++) cycle(3'b000, 1'b1, 1'b1, 1'b0);
    check("pre_clr_level", 32'(level), 32'd7);
    cycle(3'b001, 1'b1, 1'b0, 1'b1);
    check("clr_level", 32'(level), 32'd0);
    check("clr_overflow", 32'(overflow), 32'd0);
    check("clr_drops", 32'(drops), 32'd0);
    cycle(3'b000, 1'b1, 1'b0, 1'b0);
    edge0(1'b1);
    cycle(3'b000, 1'b1, 1'b0, 1'b1);

    // Edges with logging disabled.
    for (int i = 0; i < 4; i++) edge0(1'b0);
    check("disabled_level", 32'(level), 32'd0);

    // Timestamp wrap on the narrow instance: edges at ts 30, 31, 0.
    while (m_ts[4:0] != 5'd30) cycle(3'b000, 1'b1, 1'b0, 1'b0);
    cycle(3'b001, 1'b1, 1'b0, 1'b0);
    cycle(3'b011, 1'b1, 1'b0, 1'b0);
    cycle(3'b111, 1'b1, 1'b0, 1'b0);
    check("wrap0", 32'(dout2), 32'h3E);
    cycle(3'b111, 1'b1, 1'b1, 1'b0);
    check("wrap1", 32'(dout2), 32'h5F);
    cycle(3'b111, 1'b1, 1'b1, 1'b0);
    check("wrap2", 32'(dout2), 32'h80);
    cycle(3'b000, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle with level 5.
    for (int i = 0; i < 5; i++) edge0(1'b1);
    check("pre_async_level", 32'(level), 32'd5);
    #2;
    reset1 = 1'b1;
    #1;
    check("async_dout", dout, 32'd0);
    check("async_level", 32'(level), 32'd0);
    check("async_empty", 32'(empty), 32'd1);
    check("async_full", 32'(full), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    check("async_drops", 32'(drops), 32'd0);
    #2;
    model_reset();
    reset1 = 1'b0;
    ev = 3'b001;
    cycle(3'b001, 1'b1, 1'b0, 1'b0);
    check("post_rst_no_edge", 32'(level), 32'd0);
    cycle(3'b000, 1'b1, 1'b0, 1'b0);
    cycle(3'b001, 1'b1, 1'b0, 1'b0);
    check("post_rst_ts", dout, {3'b001, 29'd2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
